// File: rtl/core_mem_model.sv
// core_mem_model: in-order request queue with per-entry aging and a
// word-addressed byte-enable memory, responding under backpressure.
module core_mem_model #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int MEM_AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_ack,
  input  logic        req_cop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(LATENCY + 1);
  localparam int MW  = 2 ** MEM_AW;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic          cop_q   [DEPTH];
  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [AGW-1:0] age_q  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] mem_q [MW];

  logic              push;
  logic              pop;
  logic              nonempty;
  logic [31:0]       h_addr;
  logic [MEM_AW-1:0] h_idx;
  logic              unused_hi;

  assign nonempty  = (cnt_q != '0);
  assign h_addr    = addr_q[head_q];
  assign h_idx     = h_addr[MEM_AW+1:2];
  assign unused_hi = ^h_addr[31:MEM_AW+2];

  assign req_ack  = (cnt_q < CW'(DEPTH));
  assign resp_val = nonempty && (age_q[head_q] == '0);
  assign resp_err = nonempty && (h_addr[1:0] != 2'b00);

  always_comb begin
    resp_data = '0;
    if (nonempty && !cop_q[head_q] && !resp_err) begin
      resp_data = mem_q[h_idx];
    end
  end

  assign push = req_val && req_ack;
  assign pop  = resp_val && resp_rdy;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
    end
    if (pop) begin
      head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Every slot ages each cycle, so a stalled head does not delay its successors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_q[i] != '0) begin
          age_q[i] <= age_q[i] - AGW'(1);
        end
      end
      if (push) begin
        age_q[tail_q] <= AGW'(LATENCY);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cop_q[tail_q]   <= req_cop;
      addr_q[tail_q]  <= req_addr;
      wdata_q[tail_q] <= req_wdata;
      be_q[tail_q]    <= req_be;
    end
  end

  // Memory is never reset; writes land only on their response handshake.
  always_ff @(posedge clk) begin
    if (!rst && pop && cop_q[head_q] && !resp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[head_q][b]) begin
          mem_q[h_idx][8*b +: 8] <= wdata_q[head_q][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_model.sv
// Scoreboard bench for core_mem_model: directed scenarios plus random
// traffic checked against a queue-and-array reference model.
module tb_core_mem_model;

  localparam int L  = 2;
  localparam int D  = 4;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic        req_ack;
  logic        req_cop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;
  logic        resp_err;

  core_mem_model #(.DEPTH(D), .LATENCY(L), .MEM_AW(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_ack   (req_ack),
    .req_cop   (req_cop),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          acc;
    logic        kchk;
    logic [31:0] kdata;
    logic        kerr;
  } req_t;

  req_t        pend[$];
  logic [31:0] mem_m [2**AW];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        cur_kchk;
  logic [31:0] cur_kdata;
  logic        cur_kerr;
  logic        rnd_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      resp_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: decides at mid-cycle what the next rising edge will transfer.
  always @(negedge clk) begin
    req_t        h;
    req_t        n;
    logic        ev;
    logic        e_err;
    logic [31:0] e_data;
    logic [AW-1:0] idx;
    if (rst) begin
      pend.delete();
    end else begin
      ev = (pend.size() != 0) && (cyc >= pend[0].acc + L);
      chk("resp_val", {31'd0, resp_val}, {31'd0, ev});
      chk("req_ack", {31'd0, req_ack}, {31'd0, pend.size() < D});
      if (pend.size() == 0) begin
        chk("idle_data", resp_data, 32'd0);
        chk("idle_err", {31'd0, resp_err}, 32'd0);
      end else if (ev) begin
        h      = pend[0];
        idx    = h.addr[AW+1:2];
        e_err  = (h.addr[1:0] != 2'b00);
        e_data = (h.cop || e_err) ? 32'd0 : mem_m[idx];
        chk("resp_data", resp_data, e_data);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        if (resp_rdy) begin
          if (h.kchk) begin
            chk("dir_data", resp_data, h.kdata);
            chk("dir_err", {31'd0, resp_err}, {31'd0, h.kerr});
          end
          if (h.cop && !e_err) begin
            for (int b = 0; b < 4; b++) begin
              if (h.be[b]) mem_m[idx][8*b +: 8] = h.wdata[8*b +: 8];
            end
          end
          void'(pend.pop_front());
        end
      end
      if (req_val && req_ack) begin
        n.cop   = req_cop;
        n.addr  = req_addr;
        n.wdata = req_wdata;
        n.be    = req_be;
        n.acc   = cyc + 1;
        n.kchk  = cur_kchk;
        n.kdata = cur_kdata;
        n.kerr  = cur_kerr;
        pend.push_back(n);
      end
    end
  end

  task automatic send(input logic cop, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic kc, input logic [31:0] kd,
                      input logic ke);
    int t;
    req_cop   = cop;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    cur_kchk  = kc;
    cur_kdata = kd;
    cur_kerr  = ke;
    req_val   = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ack && t < 200);
    if (!req_ack) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_val  = 1'b0;
    cur_kchk = 1'b0;
  endtask

  task automatic drain();
    int t;
    resp_rdy = 1'b1;
    t = 0;
    while (pend.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (pend.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    for (int i = 0; i < 2**AW; i++) mem_m[i] = 32'd0;
    rst       = 1'b1;
    req_val   = 1'b0;
    req_cop   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    resp_rdy  = 1'b1;
    cur_kchk  = 1'b0;
    cur_kdata = '0;
    cur_kerr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, req_ack}, 32'd1);
    chk("rst_val", {31'd0, resp_val}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1;

    send(1'b0, 32'h300, 0, 4'h0, 1'b1, 32'd0, 1'b0);
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'd0, 1'b0);
    send(1'b0, 32'h10, 0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    send(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 0, 1'b0);
    send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 1'b0);
    send(1'b0, 32'h20, 0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0);
    drain();

    // Full queue under backpressure.
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 32'h20 + 32'(i * 4), 0, 4'h0, 1'b0, 0, 1'b0);
    end
    req_cop  = 1'b0;
    req_addr = 32'h10;
    cur_kchk = 1'b1;
    cur_kdata = 32'hDEADBEEF;
    cur_kerr = 1'b0;
    req_val  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ack", {31'd0, req_ack}, 32'd0);
    end
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("pop_cycle_ack", {31'd0, req_ack}, 32'd0);
    @(negedge clk);
    chk("after_pop_ack", {31'd0, req_ack}, 32'd1);
    @(posedge clk);
    #1;
    req_val  = 1'b0;
    cur_kchk = 1'b0;
    drain();

    send(1'b1, 32'h13, 32'h55555555, 4'hF, 1'b1, 32'd0, 1'b1);
    send(1'b0, 32'h10, 0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1'b0);
    send(1'b0, 32'h1000, 0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0);
    drain();

    // Reset with pending writes discards them.
    resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 32'h40 + 32'(i * 4), 32'h900D0000 + 32'(i), 4'hF,
           1'b0, 0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_val", {31'd0, resp_val}, 32'd0);
    chk("mid_rst_ack", {31'd0, req_ack}, 32'd1);
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 32'h40 + 32'(i * 4), 0, 4'h0, 1'b1, 32'd0, 1'b0);
    end
    send(1'b0, 32'h1010, 0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    drain();

    // Stall aging: both entries leave back to back once released.
    resp_rdy = 1'b0;
    send(1'b0, 32'h10, 0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    send(1'b0, 32'h20, 0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("stall_first", {31'd0, resp_val}, 32'd1);
    @(negedge clk);
    chk("stall_second", {31'd0, resp_val}, 32'd1);
    drain();

    rnd_on = 1'b1;
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 12);
      if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
      send($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
           1'b0, 0, 1'b0);
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
